// File: rtl/sc_llr_scheduler_pkg.sv
// Shared types and helpers for the successive-cancellation LLR scheduler.
// Holds the PE opcode, the scheduler state encoding and a trailing-zero count.
package sc_llr_scheduler_pkg;

    typedef enum logic {
        OP_F = 1'b0,
        OP_G = 1'b1
    } pe_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_DECIDE = 3'd3,
        ST_FIN    = 3'd4
    } sched_state_e;

    // Index of the lowest set bit among the low w bits of v; w when none is set.
    function automatic int ctz(input logic [31:0] v, input int w);
        int n;
        n = w;
        for (int i = 31; i >= 0; i--) begin
            if (i < w && v[i]) n = i;
        end
        return n;
    endfunction

endpackage

// File: rtl/sc_llr_scheduler_ctz.sv
// Trailing-zero count of (idx + 1): the stage at which the next bit of the
// successive-cancellation schedule re-enters the tree with a g operation.
module sc_llr_scheduler_ctz
    import sc_llr_scheduler_pkg::*;
#(
    parameter int LOG_N = 3,
    parameter int TZ_W  = 2
) (
    input  logic [LOG_N-1:0] idx,
    output logic [TZ_W-1:0]  tz
);

    logic [LOG_N-1:0] nxt;

    always_comb begin
        nxt = idx + LOG_N'(1);
        tz  = TZ_W'(ctz(32'(nxt), LOG_N));
    end

endmodule

// File: rtl/sc_llr_scheduler.sv
// Control FSM that walks a bank of P f/g LLR units through the SC schedule of
// an N = 2^LOG_N polar decoder, one bit at a time, with a PE_LAT drain per stage.
module sc_llr_scheduler
    import sc_llr_scheduler_pkg::*;
#(
    parameter int LOG_N  = 3,
    parameter int P      = 2,
    parameter int PE_LAT = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic                               pe_en,
    output logic                               pe_op,
    output logic [P-1:0]                       pe_mask,
    output logic [$clog2(LOG_N+1)-1:0]         stage,
    output logic [((LOG_N > 1) ? LOG_N-1 : 1)-1:0] grp,
    output logic                               bit_req,
    output logic [LOG_N-1:0]                   bit_idx,
    input  logic                               bit_ack
);

    localparam int STAGE_W = $clog2(LOG_N + 1);
    localparam int GRP_W   = (LOG_N > 1) ? LOG_N - 1 : 1;
    localparam int LOG_P   = $clog2(P);

    localparam logic [STAGE_W-1:0] TOP_STAGE  = STAGE_W'(LOG_N - 1);
    localparam logic [LOG_N-1:0]   LAST_IDX   = '1;
    localparam logic [2:0]         DRAIN_INIT = (PE_LAT > 0) ? 3'(PE_LAT - 1) : 3'd0;

    // Last group index of a stage: a stage spans max(1, 2^s / P) groups of P lanes.
    function automatic logic [GRP_W-1:0] last_grp(input logic [STAGE_W-1:0] s);
        int sh;
        sh = int'(s) - LOG_P;
        if (sh <= 0) return '0;
        return GRP_W'((1 << sh) - 1);
    endfunction

    // Narrow stages near the leaves only occupy the low 2^s lanes.
    function automatic logic [P-1:0] mask_of(input logic [STAGE_W-1:0] s);
        logic [P-1:0] m;
        for (int i = 0; i < P; i++) m[i] = (i < (1 << s));
        return m;
    endfunction

    sched_state_e       state;
    logic [2:0]         drain_cnt;
    logic [STAGE_W-1:0] tz_next;
    logic [STAGE_W-1:0] stage_dn;
    logic [GRP_W-1:0]   grp_last;

    sc_llr_scheduler_ctz #(
        .LOG_N (LOG_N),
        .TZ_W  (STAGE_W)
    ) u_ctz (
        .idx (bit_idx),
        .tz  (tz_next)
    );

    always_comb begin
        stage_dn = stage - STAGE_W'(1);
        grp_last = last_grp(stage);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pe_en     <= 1'b0;
            pe_op     <= OP_F;
            pe_mask   <= '0;
            stage     <= '0;
            grp       <= '0;
            bit_req   <= 1'b0;
            bit_idx   <= '0;
            drain_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_ISSUE;
                        busy    <= 1'b1;
                        pe_en   <= 1'b1;
                        pe_op   <= OP_F;
                        stage   <= TOP_STAGE;
                        grp     <= '0;
                        pe_mask <= mask_of(TOP_STAGE);
                        bit_idx <= '0;
                    end
                end
                ST_ISSUE, ST_DRAIN: begin
                    if (state == ST_ISSUE && grp != grp_last) begin
                        grp <= grp + GRP_W'(1);
                    end else if (state == ST_ISSUE && PE_LAT != 0) begin
                        state     <= ST_DRAIN;
                        pe_en     <= 1'b0;
                        drain_cnt <= DRAIN_INIT;
                    end else if (state == ST_DRAIN && drain_cnt != 3'd0) begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end else if (stage != '0) begin
                        // Descend one stage towards the leaf; every stage after the first is f.
                        state   <= ST_ISSUE;
                        pe_en   <= 1'b1;
                        pe_op   <= OP_F;
                        stage   <= stage_dn;
                        grp     <= '0;
                        pe_mask <= mask_of(stage_dn);
                    end else begin
                        state   <= ST_DECIDE;
                        pe_en   <= 1'b0;
                        bit_req <= 1'b1;
                    end
                end
                ST_DECIDE: begin
                    if (bit_ack) begin
                        bit_req <= 1'b0;
                        if (bit_idx == LAST_IDX) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            // Next bit re-enters the tree at ctz(i+1) with a g op.
                            state   <= ST_ISSUE;
                            pe_en   <= 1'b1;
                            pe_op   <= OP_G;
                            stage   <= tz_next;
                            grp     <= '0;
                            pe_mask <= mask_of(tz_next);
                            bit_idx <= bit_idx + LOG_N'(1);
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_llr_scheduler.sv
// Randomized bench for sc_llr_scheduler: a per-cycle expected trace is built
// from the SC schedule rules and compared against two DUT configurations.
module tb_sc_llr_scheduler;

    localparam int K_RST = 0;
    localparam int K_ISS = 1;
    localparam int K_CTL = 2;
    localparam int K_IDL = 3;

    typedef struct {
        int kind;
        bit en;
        bit op;
        int stg;
        int grp;
        int mask;
        bit req;
        int idx;
        bit busy;
        bit done;
        bit start_nx;
        bit ack_nx;
        bit rst_nx;
    } ent_t;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic start = 1'b0;
    logic ack = 1'b0;
    int   ph_sel = 0;

    logic       a_busy, a_done, a_en, a_op, a_req;
    logic [1:0] a_mask, a_stage, a_grp;
    logic [2:0] a_idx;
    logic       b_busy, b_done, b_en, b_op, b_req;
    logic [0:0] b_mask;
    logic [1:0] b_stage, b_grp;
    logic [2:0] b_idx;

    logic       o_busy, o_done, o_en, o_op, o_req;
    logic [7:0] o_mask, o_stage, o_grp, o_idx;

    ent_t tr[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cur_cyc = 0;

    always #5 clk = ~clk;

    sc_llr_scheduler #(.LOG_N(3), .P(2), .PE_LAT(1)) u_dut_a (
        .clk(clk), .rst_n(rst_a), .start(start), .busy(a_busy), .done(a_done),
        .pe_en(a_en), .pe_op(a_op), .pe_mask(a_mask), .stage(a_stage), .grp(a_grp),
        .bit_req(a_req), .bit_idx(a_idx), .bit_ack(ack)
    );

    sc_llr_scheduler #(.LOG_N(3), .P(1), .PE_LAT(0)) u_dut_b (
        .clk(clk), .rst_n(rst_b), .start(start), .busy(b_busy), .done(b_done),
        .pe_en(b_en), .pe_op(b_op), .pe_mask(b_mask), .stage(b_stage), .grp(b_grp),
        .bit_req(b_req), .bit_idx(b_idx), .bit_ack(ack)
    );

    always_comb begin
        if (ph_sel == 0) begin
            o_busy = a_busy; o_done = a_done; o_en = a_en; o_op = a_op; o_req = a_req;
            o_mask = 8'(a_mask); o_stage = 8'(a_stage); o_grp = 8'(a_grp); o_idx = 8'(a_idx);
        end else begin
            o_busy = b_busy; o_done = b_done; o_en = b_en; o_op = b_op; o_req = b_req;
            o_mask = 8'(b_mask); o_stage = 8'(b_stage); o_grp = 8'(b_grp); o_idx = 8'(b_idx);
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (phase %0d cycle %0d): got %0d, expected %0d", tag, ph_sel, cur_cyc, act, exp);
        end
    endtask

    function automatic int tz(input int v);
        int n;
        n = 0;
        while (v % 2 == 0 && n < 30) begin
            v = v / 2;
            n++;
        end
        return n;
    endfunction

    function automatic ent_t mk(input int kind, input bit en, input bit op, input int stg,
                                input int grp, input int mask, input bit req, input int idx,
                                input bit busy, input bit done);
        ent_t e;
        e.kind = kind; e.en = en; e.op = op; e.stg = stg; e.grp = grp; e.mask = mask;
        e.req = req; e.idx = idx; e.busy = busy; e.done = done;
        e.start_nx = busy ? bit'($urandom_range(0, 1)) : 1'b0;
        e.ack_nx   = req ? 1'b0 : bit'($urandom_range(0, 1));
        e.rst_nx   = 1'b1;
        return e;
    endfunction

    task automatic gen_idle(input int k, input bit go);
        ent_t e;
        for (int j = 0; j < k; j++) begin
            e = mk(K_IDL, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (j == k - 1) e.start_nx = go;
            tr.push_back(e);
        end
    endtask

    task automatic gen_reset();
        tr.push_back(mk(K_RST, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    // One codeword from the SC rules: bit i enters at stage ctz(i) (root for bit 0),
    // g only on that entry stage, max(1, 2^s/P) groups per stage, lat idle cycles after each.
    task automatic gen_word(input int logn, input int p, input int lat, input int abort_bit,
                            input int wait_max, input int force_bit);
        int   n, first, gcnt, m, w;
        ent_t e;
        n = 1 << logn;
        for (int i = 0; i < n; i++) begin
            first = (i == 0) ? logn - 1 : tz(i);
            for (int s = first; s >= 0; s--) begin
                gcnt = ((1 << s) / p > 1) ? (1 << s) / p : 1;
                m    = ((1 << s) >= p) ? (1 << p) - 1 : (1 << (1 << s)) - 1;
                for (int g = 0; g < gcnt; g++) begin
                    e = mk(K_ISS, 1, (s == first && i > 0), s, g, m, 0, i, 1, 0);
                    if (i == abort_bit) begin
                        e.rst_nx = 1'b0;
                        e.start_nx = 1'b0;
                        tr.push_back(e);
                        return;
                    end
                    tr.push_back(e);
                end
                for (int d = 0; d < lat; d++) tr.push_back(mk(K_CTL, 0, 0, 0, 0, 0, 0, i, 1, 0));
            end
            w = (i == force_bit) ? 5 : int'($urandom_range(0, wait_max));
            for (int k = 0; k < w; k++) tr.push_back(mk(K_CTL, 0, 0, 0, 0, 0, 1, i, 1, 0));
            e = mk(K_CTL, 0, 0, 0, 0, 0, 1, i, 1, 0);
            e.ack_nx = 1'b1;
            tr.push_back(e);
        end
        tr.push_back(mk(K_IDL, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    endtask

    task automatic build(input int logn, input int p, input int lat);
        tr.delete();
        gen_reset();
        gen_idle(1, 1);
        gen_word(logn, p, lat, -1, 2, -1);
        gen_idle(int'($urandom_range(1, 3)), 1);
        gen_word(logn, p, lat, -1, 5, 5);
        gen_idle(1, 1);
        gen_word(logn, p, lat, 3, 1, -1);
        gen_reset();
        gen_idle(1, 1);
        gen_word(logn, p, lat, -1, 1, -1);
        gen_idle(3, 0);
    endtask

    task automatic run_phase(input int ph);
        ent_t e;
        int en_exp, en_act, dn_exp, dn_act;
        en_exp = 0; en_act = 0; dn_exp = 0; dn_act = 0;
        for (int c = 0; c < tr.size(); c++) begin
            @(negedge clk);
            cur_cyc = c;
            e = tr[c];
            chk("pe_en", 32'(o_en), 32'(e.en));
            chk("busy", 32'(o_busy), 32'(e.busy));
            chk("done", 32'(o_done), 32'(e.done));
            chk("bit_req", 32'(o_req), 32'(e.req));
            if (e.kind == K_ISS || e.kind == K_RST) begin
                chk("pe_op", 32'(o_op), 32'(e.op));
                chk("stage", 32'(o_stage), e.stg);
                chk("grp", 32'(o_grp), e.grp);
                chk("pe_mask", 32'(o_mask), e.mask);
            end
            if (e.kind != K_IDL) chk("bit_idx", 32'(o_idx), e.idx);
            if (e.en) en_exp++;
            if (o_en === 1'b1) en_act++;
            if (e.done) dn_exp++;
            if (o_done === 1'b1) dn_act++;
            start = e.start_nx;
            ack   = e.ack_nx;
            if (ph == 0) rst_a = e.rst_nx;
            else         rst_b = e.rst_nx;
        end
        chk("pe_en_total", en_act, en_exp);
        chk("done_total", dn_act, dn_exp);
    endtask

    initial begin
        ph_sel = 0;
        build(3, 2, 1);
        run_phase(0);
        rst_a  = 1'b0;
        ph_sel = 1;
        build(3, 1, 0);
        run_phase(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
